// File: rtl/hamming_decoder_pipe.sv
// -----------------------------------------------------------------------------
// hamming_decoder_pipe
//   Receive-side Hamming(7,4) decoder. Two-stage valid/ready pipeline:
//     stage 1 registers the incoming codeword together with its 3-bit syndrome,
//     stage 2 flips the bit the syndrome points at and registers the corrected
//     4-bit data word, the syndrome and a "corrected" flag.
//   Saturating statistics counters track delivered words and delivered words
//   that needed a correction. Double-bit errors alias onto a single-bit
//   syndrome and are silently miscorrected; (7,4) cannot tell them apart.
//
// Ports
//   clk_i            clock, all state on posedge
//   rst_i            synchronous active-high reset
//   in_valid_i       code_in_i carries a codeword
//   in_ready_o       stage 1 can accept this cycle (combinational)
//   code_in_i [6:0]  codeword, bit i = Hamming position i+1
//                    [0]p1 [1]p2 [2]d1 [3]p4 [4]d2 [5]d3 [6]d4
//   out_valid_o      data_out_o / syndrome_out_o / corrected_out_o valid
//   out_ready_i      downstream accepts
//   data_out_o [3:0] corrected {d4,d3,d2,d1}
//   syndrome_out_o   {s4,s2,s1}; 0 = clean, else 1-based flipped position
//   corrected_out_o  1 when syndrome_out_o != 0
//   cnt_clr_i        synchronous clear of both counters (beats increments)
//   word_cnt_o       delivered words, saturating
//   corr_cnt_o       delivered words with corrected_out_o = 1, saturating
// -----------------------------------------------------------------------------
module hamming_decoder_pipe #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [6:0]       code_in_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [3:0]       data_out_o,
    output logic [2:0]       syndrome_out_o,
    output logic             corrected_out_o,
    input  logic             cnt_clr_i,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic [CNT_W-1:0] corr_cnt_o
);

    // Parity checks over the positions whose index has bit 0 / 1 / 2 set.
    function automatic logic [2:0] calc_syndrome(input logic [6:0] c);
        logic s1;
        logic s2;
        logic s4;
        s1 = c[0] ^ c[2] ^ c[4] ^ c[6];
        s2 = c[1] ^ c[2] ^ c[5] ^ c[6];
        s4 = c[3] ^ c[4] ^ c[5] ^ c[6];
        return {s4, s2, s1};
    endfunction

    // One-hot mask selecting codeword bit (syn-1); zero for a clean word.
    function automatic logic [6:0] flip_mask(input logic [2:0] syn);
        logic [6:0] m;
        case (syn)
            3'd0:    m = 7'b000_0000;
            3'd1:    m = 7'b000_0001;
            3'd2:    m = 7'b000_0010;
            3'd3:    m = 7'b000_0100;
            3'd4:    m = 7'b000_1000;
            3'd5:    m = 7'b001_0000;
            3'd6:    m = 7'b010_0000;
            3'd7:    m = 7'b100_0000;
            default: m = 7'b000_0000;
        endcase
        return m;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Stage 1 state
    logic             v1_q,       v1_d;
    logic [6:0]       code1_q,    code1_d;
    logic [2:0]       syn1_q,     syn1_d;
    // Stage 2 (output) state
    logic             v2_q,       v2_d;
    logic [3:0]       data2_q,    data2_d;
    logic [2:0]       syn2_q,     syn2_d;
    logic             corr2_q,    corr2_d;
    // Statistics
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;

    logic             en1_s;
    logic             en2_s;
    logic             out_fire_s;
    logic [6:0]       fixed_s;

    // Pipeline enables: stage 2 advances when empty or drained; stage 1
    // advances when empty or when stage 2 makes room, so bubbles collapse.
    always_comb begin
        en2_s      = !v2_q || out_ready_i;
        en1_s      = !v1_q || en2_s;
        out_fire_s = v2_q && out_ready_i;
        fixed_s    = code1_q ^ flip_mask(syn1_q);
    end

    assign in_ready_o = en1_s;

    // Stage 1 next state: capture codeword and its syndrome.
    always_comb begin
        v1_d    = v1_q;
        code1_d = code1_q;
        syn1_d  = syn1_q;
        if (en1_s) begin
            v1_d    = in_valid_i;
            code1_d = code_in_i;
            syn1_d  = calc_syndrome(code_in_i);
        end else begin
            v1_d    = v1_q;
        end
    end

    // Stage 2 next state: apply correction and extract data bits.
    always_comb begin
        v2_d    = v2_q;
        data2_d = data2_q;
        syn2_d  = syn2_q;
        corr2_d = corr2_q;
        if (en2_s) begin
            v2_d    = v1_q;
            data2_d = {fixed_s[6], fixed_s[5], fixed_s[4], fixed_s[2]};
            syn2_d  = syn1_q;
            corr2_d = (syn1_q != 3'd0);
        end else begin
            v2_d    = v2_q;
        end
    end

    // Counter next state: clear wins over a same-cycle delivery.
    always_comb begin
        word_cnt_d = word_cnt_q;
        corr_cnt_d = corr_cnt_q;
        if (cnt_clr_i) begin
            word_cnt_d = {CNT_W{1'b0}};
            corr_cnt_d = {CNT_W{1'b0}};
        end else if (out_fire_s) begin
            word_cnt_d = sat_inc(word_cnt_q);
            if (corr2_q) begin
                corr_cnt_d = sat_inc(corr_cnt_q);
            end else begin
                corr_cnt_d = corr_cnt_q;
            end
        end else begin
            word_cnt_d = word_cnt_q;
            corr_cnt_d = corr_cnt_q;
        end
    end

    // State registers; reset discards in-flight words and zeroes statistics.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q       <= 1'b0;
            code1_q    <= 7'd0;
            syn1_q     <= 3'd0;
            v2_q       <= 1'b0;
            data2_q    <= 4'd0;
            syn2_q     <= 3'd0;
            corr2_q    <= 1'b0;
            word_cnt_q <= {CNT_W{1'b0}};
            corr_cnt_q <= {CNT_W{1'b0}};
        end else begin
            v1_q       <= v1_d;
            code1_q    <= code1_d;
            syn1_q     <= syn1_d;
            v2_q       <= v2_d;
            data2_q    <= data2_d;
            syn2_q     <= syn2_d;
            corr2_q    <= corr2_d;
            word_cnt_q <= word_cnt_d;
            corr_cnt_q <= corr_cnt_d;
        end
    end

    assign out_valid_o     = v2_q;
    assign data_out_o      = data2_q;
    assign syndrome_out_o  = syn2_q;
    assign corrected_out_o = corr2_q;
    assign word_cnt_o      = word_cnt_q;
    assign corr_cnt_o      = corr_cnt_q;

    hamming_decoder_pipe_chk u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .out_valid_i (v2_q),
        .out_ready_i (out_ready_i),
        .data_i      (data2_q),
        .syn_i       (syn2_q),
        .corr_i      (corr2_q)
    );

endmodule

// -----------------------------------------------------------------------------
// hamming_decoder_pipe_chk
//   Protocol properties of the decoder output port: a stalled word must stay
//   put, and the corrected flag must always agree with the syndrome.
// Ports: clock/reset plus the registered output-side signals of the decoder.
// -----------------------------------------------------------------------------
module hamming_decoder_pipe_chk (
    input logic       clk_i,
    input logic       rst_i,
    input logic       out_valid_i,
    input logic       out_ready_i,
    input logic [3:0] data_i,
    input logic [2:0] syn_i,
    input logic       corr_i
);

    property p_stall_hold;
        @(posedge clk_i) disable iff (rst_i)
            (out_valid_i && !out_ready_i) |=>
                (out_valid_i && $stable(data_i) && $stable(syn_i) && $stable(corr_i));
    endproperty

    property p_flag_matches_syndrome;
        @(posedge clk_i) corr_i == (syn_i != 3'd0);
    endproperty

    a_stall_hold:  assert property (p_stall_hold);
    a_flag_match:  assert property (p_flag_matches_syndrome);

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// Self-checking bench for hamming_decoder_pipe. A 16-bit-counter instance and
// a 2-bit-counter instance share the same stimulus. The reference model keeps
// accepted codewords in a queue tagged with their acceptance edge and decodes
// them by brute-force search over all (data, single-flip) combinations.
module tb_hamming_decoder_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [6:0]  code;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready,  in_ready_s;
    logic        out_valid, out_valid_s;
    logic [3:0]  data_out,  data_out_s;
    logic [2:0]  syn_out,   syn_out_s;
    logic        corr_out,  corr_out_s;
    logic [15:0] word_cnt,  corr_cnt;
    logic [1:0]  word_cnt_s, corr_cnt_s;

    hamming_decoder_pipe #(.CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .code_in_i(code), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .data_out_o(data_out), .syndrome_out_o(syn_out), .corrected_out_o(corr_out),
        .cnt_clr_i(cnt_clr), .word_cnt_o(word_cnt), .corr_cnt_o(corr_cnt)
    );

    hamming_decoder_pipe #(.CNT_W(2)) dut_s (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_s),
        .code_in_i(code), .out_valid_o(out_valid_s), .out_ready_i(out_ready),
        .data_out_o(data_out_s), .syndrome_out_o(syn_out_s), .corrected_out_o(corr_out_s),
        .cnt_clr_i(cnt_clr), .word_cnt_o(word_cnt_s), .corr_cnt_o(corr_cnt_s)
    );

    int          checks = 0;
    int          errors = 0;
    logic [6:0]  q_code[$];
    int          q_edge[$];
    int          edge_cnt = 0;
    int          delivered = 0;
    int          w16 = 0, c16 = 0, w2 = 0, c2 = 0;
    bit          hs_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Encoder from the definition: each parity bit covers the data bits
    // whose position index shares that power of two.
    function automatic logic [6:0] enc(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    function automatic logic [6:0] flip(input int e);
        logic [6:0] m;
        m = 7'd0;
        if (e > 0) m[e-1] = 1'b1;
        return m;
    endfunction

    // Nearest-codeword decode: the (7,4) code is perfect, so exactly one
    // (data, flip) pair reproduces any 7-bit pattern.
    task automatic ref_decode(input logic [6:0] c, output logic [3:0] d, output logic [2:0] s);
        d = 4'd0;
        s = 3'd0;
        for (int dd = 0; dd < 16; dd++)
            for (int e = 0; e < 8; e++)
                if ((enc(4'(dd)) ^ flip(e)) == c) begin
                    d = 4'(dd);
                    s = 3'(e);
                end
    endtask

    // One clock: check outputs against the model, predict handshakes,
    // cross the edge, update the model.
    task automatic tick();
        logic [3:0] ed;
        logic [2:0] es;
        logic       ov_exp;
        logic       ir_exp;
        logic       hs_out;
        #1;
        ov_exp = 1'b0;
        if (q_code.size() > 0) ov_exp = (edge_cnt > q_edge[0]);
        ir_exp = (q_code.size() < 2) || out_ready;
        chk("out_valid",   32'(out_valid),   32'(ov_exp));
        chk("in_ready",    32'(in_ready),    32'(ir_exp));
        chk("out_valid_s", 32'(out_valid_s), 32'(ov_exp));
        if (ov_exp) begin
            ref_decode(q_code[0], ed, es);
            chk("data_out",      32'(data_out), 32'(ed));
            chk("syndrome_out",  32'(syn_out),  32'(es));
            chk("corrected_out", 32'(corr_out), 32'(es != 3'd0));
        end
        chk("word_cnt",   32'(word_cnt),   32'(w16));
        chk("corr_cnt",   32'(corr_cnt),   32'(c16));
        chk("word_cnt_s", 32'(word_cnt_s), 32'(w2));
        chk("corr_cnt_s", 32'(corr_cnt_s), 32'(c2));
        hs_in  = in_valid && ir_exp && !rst;
        hs_out = ov_exp && out_ready && !rst;
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            q_code.delete();
            q_edge.delete();
            w16 = 0; c16 = 0; w2 = 0; c2 = 0;
        end else begin
            if (hs_out) begin
                ref_decode(q_code[0], ed, es);
                delivered++;
                void'(q_code.pop_front());
                void'(q_edge.pop_front());
                if (!cnt_clr) begin
                    if (w16 < 65535) w16++;
                    if (w2 < 3) w2++;
                    if (es != 3'd0) begin
                        if (c16 < 65535) c16++;
                        if (c2 < 3) c2++;
                    end
                end
            end
            if (cnt_clr) begin
                w16 = 0; c16 = 0; w2 = 0; c2 = 0;
            end
            if (hs_in) begin
                q_code.push_back(code);
                q_edge.push_back(edge_cnt);
            end
        end
        #1;
    endtask

    int         idx;
    logic [3:0] held;

    initial begin
        rst = 1'b1; in_valid = 1'b0; code = 7'd0; out_ready = 1'b1; cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        edge_cnt = 1;
        tick();
        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data",      32'(data_out),  32'd0);
        chk("rst_syn",       32'(syn_out),   32'd0);
        chk("rst_corr",      32'(corr_out),  32'd0);
        chk("rst_word_cnt",  32'(word_cnt),  32'd0);
        rst = 1'b0;
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        // Clean word 0x55 -> data B, two cycles of latency
        in_valid = 1'b1; code = 7'h55;
        tick();
        in_valid = 1'b0;
        chk("t1_not_yet", 32'(out_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data",  32'(data_out),  32'hB);
        chk("t1_syn",   32'(syn_out),   32'd0);
        chk("t1_corr",  32'(corr_out),  32'd0);
        tick();
        chk("t1_word_cnt", 32'(word_cnt), 32'd1);

        // Single error at position 5
        in_valid = 1'b1; code = 7'h45;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t2_data", 32'(data_out), 32'hB);
        chk("t2_syn",  32'(syn_out),  32'd5);
        chk("t2_corr", 32'(corr_out), 32'd1);
        tick();
        chk("t2_corr_cnt", 32'(corr_cnt), 32'd1);

        // Exhaustive: every data value with every single-error pattern
        delivered = 0;
        for (int d = 0; d < 16; d++)
            for (int e = 0; e < 8; e++) begin
                in_valid = 1'b1;
                code = enc(4'(d)) ^ flip(e);
                tick();
            end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("exh_delivered", 32'(delivered), 32'd128);

        // Backpressure: out_ready low for 5 cycles while 8 words stream in
        delivered = 0; idx = 0; held = 4'd0;
        for (int cyc = 0; cyc < 60 && delivered < 8; cyc++) begin
            out_ready = (cyc >= 5);
            in_valid  = (idx < 8);
            code      = enc(4'(idx + 3)) ^ flip(idx % 8);
            tick();
            if (hs_in) idx++;
            if (cyc == 2) held = data_out;
            if (cyc == 4) begin
                chk("bp_accepted", 32'(idx), 32'd2);
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_stable", 32'(data_out), 32'(held));
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_delivered", 32'(delivered), 32'd8);

        // Counter saturation and clear priority
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_word_cnt_s", 32'(word_cnt_s), 32'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            code = enc(4'(i + 9)) ^ flip(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("sat_word_cnt_s", 32'(word_cnt_s), 32'd3);
        chk("sat_corr_cnt_s", 32'(corr_cnt_s), 32'd3);
        chk("word_cnt_16",    32'(word_cnt),   32'd5);
        chk("corr_cnt_16",    32'(corr_cnt),   32'd4);
        in_valid = 1'b1; code = enc(4'h6) ^ flip(2);
        tick();
        in_valid = 1'b0;
        tick();
        chk("clr_hs_valid", 32'(out_valid), 32'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_hs_word_cnt",   32'(word_cnt),   32'd0);
        chk("clr_hs_corr_cnt",   32'(corr_cnt),   32'd0);
        chk("clr_hs_word_cnt_s", 32'(word_cnt_s), 32'd0);
        chk("clr_hs_drained",    32'(out_valid),  32'd0);

        // Random traffic, including arbitrary (double-error) patterns
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            code      = 7'($urandom_range(0, 127));
            cnt_clr   = ($urandom_range(0, 49) == 0);
            tick();
        end
        cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // Reset with both stages full
        out_ready = 1'b0; in_valid = 1'b1; code = enc(4'hA);
        tick();
        code = enc(4'h3) ^ flip(6);
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_full_in_ready", 32'(in_ready),  32'd0);
        chk("mid_full_valid",    32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid",    32'(out_valid), 32'd0);
        chk("mid_rst_word_cnt", 32'(word_cnt),  32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_stale", 32'(out_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
